// File: rtl/cdb_requester.sv
// CDB requester: queues unit results and drives one per grant; get_bus the cycle after a push, payload the cycle after the grant.
// Backpressure via o_ready (!full), overflow pushes are dropped; define CDB_BACK_TO_BACK_EN for one result per cycle under continuous grant.

module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  pop_dat,
  output logic [AW:0]   count,
  output logic [AW:0]   count_nxt
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign pop_dat = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
    if (flush) count_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_dat;
  end

endmodule

module cdb_requester #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int TAG_W = 6,
  parameter int ARN_W = 5
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [XLEN-1:0]  i_result,
  input  logic [TAG_W-1:0] i_tag,
  input  logic [ARN_W-1:0] i_arn,
  output logic             o_ready,
  output logic             o_get_bus,
  input  logic             i_bus_granted,
  input  logic             i_bus_selected,
  output logic             o_cdb_valid,
  output logic [XLEN-1:0]  o_cdb_result,
  output logic [TAG_W-1:0] o_cdb_tag,
  output logic [ARN_W-1:0] o_cdb_arn
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag;
    logic [ARN_W-1:0] arn;
  } cdb_dat_t;

  localparam int EW = $bits(cdb_dat_t);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          push;
  logic          load;
  logic          grant;
  logic [EW-1:0] head_raw;
  cdb_dat_t      in_dat;
  cdb_dat_t      head;
  cdb_dat_t      out_q;

  assign in_dat.result = i_result;
  assign in_dat.tag    = i_tag;
  assign in_dat.arn    = i_arn;
  assign head          = head_raw;

  assign o_ready = (count != FULL_CNT);
  assign push    = i_valid && o_ready && !i_flush;
  assign grant   = i_bus_granted && i_bus_selected;

`ifdef CDB_BACK_TO_BACK_EN
  assign o_get_bus = (state == S_REQ) || ((state == S_DRIVE) && (count != '0));
`else
  assign o_get_bus = (state == S_REQ);
`endif

  // A grant only counts while the request is visible to the arbiter.
  assign load = o_get_bus && grant && !i_flush;

  sync_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (i_clock),
    .rst_n     (i_reset_n),
    .flush     (i_flush),
    .push      (push),
    .push_dat  (in_dat),
    .pop       (load),
    .pop_dat   (head_raw),
    .count     (count),
    .count_nxt (count_nxt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = (count_nxt != '0) ? S_REQ : S_IDLE;
      S_REQ:   state_nxt = load ? S_DRIVE : S_REQ;
      S_DRIVE: begin
        if (load) state_nxt = S_DRIVE;
        else      state_nxt = (count_nxt != '0) ? S_REQ : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (i_flush) state_nxt = S_IDLE;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= S_IDLE;
      out_q <= '0;
    end else begin
      state <= state_nxt;
      // Cleared whenever not loaded so the shared bus sees zeros outside DRIVE.
      out_q <= load ? head : '0;
    end
  end

  assign o_cdb_valid  = (state == S_DRIVE);
  assign o_cdb_result = out_q.result;
  assign o_cdb_tag    = out_q.tag;
  assign o_cdb_arn    = out_q.arn;

endmodule

// File: tb/tb_cdb_requester.sv
// Bench for cdb_requester: directed scenarios plus random traffic against a queue-based reference model.
module tb_cdb_requester;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int TAG_W = 6;
  localparam int ARN_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             valid;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] tag;
  logic [ARN_W-1:0] arn;
  logic             ready;
  logic             get_bus;
  logic             gnt;
  logic             sel;
  logic             cdb_valid;
  logic [XLEN-1:0]  cdb_result;
  logic [TAG_W-1:0] cdb_tag;
  logic [ARN_W-1:0] cdb_arn;

  cdb_requester #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN),
    .TAG_W (TAG_W),
    .ARN_W (ARN_W)
  ) dut (
    .i_clock        (clk),
    .i_reset_n      (rst_n),
    .i_flush        (flush),
    .i_valid        (valid),
    .i_result       (result),
    .i_tag          (tag),
    .i_arn          (arn),
    .o_ready        (ready),
    .o_get_bus      (get_bus),
    .i_bus_granted  (gnt),
    .i_bus_selected (sel),
    .o_cdb_valid    (cdb_valid),
    .o_cdb_result   (cdb_result),
    .o_cdb_tag      (cdb_tag),
    .o_cdb_arn      (cdb_arn)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0]  r;
    logic [TAG_W-1:0] t;
    logic [ARN_W-1:0] a;
  } ent_t;

  ent_t q[$];
  bit   drv;
  ent_t drv_e;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, obs, exp, $time);
  endtask

  // Model: a request is visible whenever results wait and (without back-to-back) nothing is on the bus.
  function automatic bit exp_get_bus();
`ifdef CDB_BACK_TO_BACK_EN
    return q.size() != 0;
`else
    return !drv && (q.size() != 0);
`endif
  endfunction

  task automatic check_outputs(input string pfx);
    check({pfx, "_valid"},   64'(cdb_valid),  64'(drv));
    check({pfx, "_result"},  64'(cdb_result), drv ? 64'(drv_e.r) : 64'd0);
    check({pfx, "_tag"},     64'(cdb_tag),    drv ? 64'(drv_e.t) : 64'd0);
    check({pfx, "_arn"},     64'(cdb_arn),    drv ? 64'(drv_e.a) : 64'd0);
    check({pfx, "_get_bus"}, 64'(get_bus),    64'(exp_get_bus()));
    check({pfx, "_ready"},   64'(ready),      64'(q.size() < DEPTH));
  endtask

  task automatic model_reset();
    q.delete();
    drv = 0;
    drv_e = '{r: '0, t: '0, a: '0};
  endtask

  // Called at a negedge: apply inputs, advance one edge in model and DUT, check at next negedge.
  task automatic step(input string pfx, input bit v, input logic [XLEN-1:0] r,
                      input logic [TAG_W-1:0] t, input logic [ARN_W-1:0] a,
                      input bit g, input bit s, input bit f);
    bit   gb;
    bit   take;
    bit   granted;
    ent_t e;
    valid = v; result = r; tag = t; arn = a; gnt = g; sel = s; flush = f;
    gb   = exp_get_bus();
    take = v && (q.size() < DEPTH);
    e    = '{r: r, t: t, a: a};
    @(posedge clk);
    if (f) begin
      q.delete();
      drv = 0;
    end else begin
      granted = gb && g && s;
      drv = granted;
      if (granted) drv_e = q.pop_front();
      if (take) q.push_back(e);
    end
    @(negedge clk);
    check_outputs(pfx);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 0; valid = 0; result = '0; tag = '0; arn = '0; gnt = 0; sel = 0;
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single result with grant held
    step("single0", 1, 32'hDEADBEEF, 6'd5, 5'd3, 1, 1, 0);
    check("single_get_bus_c1", 64'(get_bus), 64'd1);
    step("single1", 0, '0, '0, '0, 1, 1, 0);
    check("single_result_c2", 64'(cdb_result), 64'hDEADBEEF);
    for (int i = 0; i < 3; i++) step("single_tail", 0, '0, '0, '0, 1, 1, 0);

    // Withheld grant
    step("withhold_push", 1, 32'h1234, 6'd9, 5'd7, 1, 0, 0);
    for (int i = 0; i < 4; i++) step("withhold", 0, '0, '0, '0, 1, 0, 0);
    step("withhold_sel", 0, '0, '0, '0, 1, 1, 0);
    check("withhold_drive", 64'(cdb_valid), 64'd1);
    for (int i = 0; i < 2; i++) step("withhold_tail", 0, '0, '0, '0, 0, 0, 0);

    // Full and drop
    for (int i = 1; i <= 5; i++) step("full_push", 1, 32'(i), 6'(i), 5'(i), 0, 0, 0);
    check("full_ready_low", 64'(ready), 64'd0);
    for (int i = 0; i < 10; i++) step("full_drain", 0, '0, '0, '0, 1, 1, 0);

    // Flush concurrent with grant and push
    for (int i = 1; i <= 3; i++) step("flush_fill", 1, 32'(i + 16), 6'(i), 5'(i), 0, 0, 0);
    step("flush", 1, 32'hFF, 6'd1, 5'd1, 1, 1, 1);
    check("flush_idle_ready", 64'(ready), 64'd1);
    for (int i = 0; i < 2; i++) step("flush_after", 0, '0, '0, '0, 1, 1, 0);

    // Asynchronous reset while driving
    step("rst_push", 1, 32'hCAFEF00D, 6'd33, 5'd17, 1, 1, 0);
    step("rst_drive", 0, '0, '0, '0, 1, 1, 0);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Four queued, then grant held
    for (int i = 0; i < 4; i++) step("b2b_fill", 1, 32'(32'hA0 + i), 6'(i + 40), 5'(i + 20), 0, 0, 0);
    for (int i = 0; i < 10; i++) step("b2b_drain", 0, '0, '0, '0, 1, 1, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step("rand",
           $urandom_range(0, 99) < 55,
           $urandom, 6'($urandom), 5'($urandom),
           $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 70,
           $urandom_range(0, 63) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
